// File: rtl/mult_pipe.sv
// Pipelined RV32M/RV64M multiplier: one SHIFT-bit multiplier digit is accumulated per stage,
// with bubble-collapsing backpressure and same-cycle branch kill/clear on every stage.
module mult_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 4,
  parameter int BM_W   = 4,
  parameter int TAG_W  = 6
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [1:0]                     in_func,
  input  logic [XLEN-1:0]                in_rs1,
  input  logic [XLEN-1:0]                in_rs2,
  input  logic [TAG_W-1:0]               in_tag,
  input  logic [BM_W-1:0]                in_bm,
  input  logic [BM_W-1:0]                br_resolve,
  input  logic                           br_mispred,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [XLEN-1:0]                out_result,
  output logic [TAG_W-1:0]               out_tag,
  output logic [BM_W-1:0]                out_bm,
  output logic [$clog2(STAGES+1)-1:0]    occupancy
);

  localparam int W2    = 2 * XLEN;
  localparam int SHIFT = W2 / STAGES;
  localparam int OCC_W = $clog2(STAGES + 1);

  logic [STAGES-1:0] valid_q, valid_d, eff_v, adv;
  logic [1:0]        func_q   [STAGES];
  logic [1:0]        func_d   [STAGES];
  logic [TAG_W-1:0]  tag_q    [STAGES];
  logic [TAG_W-1:0]  tag_d    [STAGES];
  logic [BM_W-1:0]   bm_q     [STAGES];
  logic [BM_W-1:0]   bm_d     [STAGES];
  logic [BM_W-1:0]   bm_clr   [STAGES];
  logic [W2-1:0]     mcand_q  [STAGES];
  logic [W2-1:0]     mcand_d  [STAGES];
  logic [W2-1:0]     mplier_q [STAGES];
  logic [W2-1:0]     mplier_d [STAGES];
  logic [W2-1:0]     acc_q    [STAGES];
  logic [W2-1:0]     acc_d    [STAGES];
  logic [OCC_W-1:0]  occupancy_q, occ_d;
  logic [W2-1:0]     rs1_ext, rs2_ext;
  logic              in_kill;

  function automatic logic [W2-1:0] extend(input logic [XLEN-1:0] v, input logic sgn);
    return sgn ? {{XLEN{v[XLEN-1]}}, v} : {{XLEN{1'b0}}, v};
  endfunction

  // Accumulate the low multiplier digit times the (already shifted) multiplicand, mod 2^W2.
  function automatic logic [W2-1:0] pp_step(input logic [W2-1:0] acc,
                                            input logic [W2-1:0] mcand,
                                            input logic [W2-1:0] mplier);
    logic [W2-1:0] digit;
    digit = '0;
    digit[SHIFT-1:0] = mplier[SHIFT-1:0];
    return acc + mcand * digit;
  endfunction

  always_comb begin
    eff_v = '0;
    for (int k = 0; k < STAGES; k++) begin
      bm_clr[k] = bm_q[k] & ~br_resolve;
      eff_v[k]  = valid_q[k] & ~(br_mispred & (|(bm_q[k] & br_resolve)));
    end
  end

  // A stage moves on when its successor moves on or is empty (killed ops count as empty).
  always_comb begin
    logic go;
    adv = '0;
    go  = out_ready | ~eff_v[STAGES-1];
    adv[STAGES-1] = go;
    for (int k = STAGES - 2; k >= 0; k--) begin
      go     = go | ~eff_v[k+1];
      adv[k] = go;
    end
  end

  assign in_ready = adv[0];

  always_comb begin
    in_kill = br_mispred & (|(in_bm & br_resolve));
    rs1_ext = extend(in_rs1, in_func != 2'b11);
    rs2_ext = extend(in_rs2, ~in_func[1]);
    valid_d = eff_v;
    for (int k = 0; k < STAGES; k++) begin
      func_d[k]   = func_q[k];
      tag_d[k]    = tag_q[k];
      bm_d[k]     = bm_clr[k];
      mcand_d[k]  = mcand_q[k];
      mplier_d[k] = mplier_q[k];
      acc_d[k]    = acc_q[k];
    end
    if (adv[0]) begin
      valid_d[0]  = in_valid & ~in_kill;
      func_d[0]   = in_func;
      tag_d[0]    = in_tag;
      bm_d[0]     = in_bm & ~br_resolve;
      mcand_d[0]  = rs1_ext << SHIFT;
      mplier_d[0] = rs2_ext >> SHIFT;
      acc_d[0]    = pp_step('0, rs1_ext, rs2_ext);
    end
    for (int k = 1; k < STAGES; k++) begin
      if (adv[k-1]) begin
        valid_d[k]  = eff_v[k-1];
        func_d[k]   = func_q[k-1];
        tag_d[k]    = tag_q[k-1];
        bm_d[k]     = bm_clr[k-1];
        mcand_d[k]  = mcand_q[k-1] << SHIFT;
        mplier_d[k] = mplier_q[k-1] >> SHIFT;
        acc_d[k]    = pp_step(acc_q[k-1], mcand_q[k-1], mplier_q[k-1]);
      end
    end
    occ_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      occ_d = occ_d + OCC_W'(valid_d[k]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q     <= '0;
      occupancy_q <= '0;
    end else begin
      valid_q     <= valid_d;
      occupancy_q <= occ_d;
    end
  end

  // Payload registers carry no reset: they are only observed behind a valid bit.
  always_ff @(posedge clock) begin
    func_q   <= func_d;
    tag_q    <= tag_d;
    bm_q     <= bm_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    acc_q    <= acc_d;
  end

  always_comb begin
    out_valid  = eff_v[STAGES-1];
    out_result = '0;
    out_tag    = '0;
    out_bm     = '0;
    if (out_valid) begin
      out_result = (func_q[STAGES-1] == 2'b00) ? acc_q[STAGES-1][XLEN-1:0]
                                               : acc_q[STAGES-1][W2-1:XLEN];
      out_tag    = tag_q[STAGES-1];
      out_bm     = bm_clr[STAGES-1];
    end
  end

  assign occupancy = occupancy_q;

endmodule

// File: tb/tb_mult_pipe.sv
// Scoreboard bench for mult_pipe (XLEN=32, STAGES=4): directed ops with hand-computed results.
module tb_mult_pipe;

  localparam int STG = 4;

  logic        clock, reset;
  logic        in_valid, in_ready;
  logic [1:0]  in_func;
  logic [31:0] in_rs1, in_rs2;
  logic [5:0]  in_tag;
  logic [3:0]  in_bm, br_resolve;
  logic        br_mispred;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [5:0]  out_tag;
  logic [3:0]  out_bm;
  logic [2:0]  occupancy;

  typedef struct {
    logic [31:0] res;
    logic [5:0]  tag;
    logic [3:0]  bm;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  localparam logic [1:0]  T3F [4] = '{2'b00, 2'b00, 2'b11, 2'b01};
  localparam logic [31:0] T3A [4] = '{32'd3, 32'd100, 32'h0001_0000, 32'hFFFF_FFFF};
  localparam logic [31:0] T3B [4] = '{32'd4, 32'hFFFF_FFFF, 32'h0001_0000, 32'hFFFF_FFFF};
  localparam logic [31:0] T3R [4] = '{32'd12, 32'hFFFF_FF9C, 32'd1, 32'd0};

  mult_pipe #(.XLEN(32), .STAGES(STG), .BM_W(4), .TAG_W(6)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag), .in_bm(in_bm),
    .br_resolve(br_resolve), .br_mispred(br_mispred),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_bm(out_bm), .occupancy(occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got tag %0h result %0h with nothing expected", out_tag, out_result);
      end else begin
        e = sb.pop_front();
        chk("result", 64'(out_result), 64'(e.res));
        chk("tag", 64'(out_tag), 64'(e.tag));
        chk("out_bm", 64'(out_bm), 64'(e.bm));
        if (e.cyc >= 0) chk("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] tg, input logic [3:0] bm, input logic [31:0] er,
                       input logic [3:0] ebm, input bit live, input bit lat, input bit must_ready);
    int   n;
    exp_t e;
    in_valid = 1'b1; in_func = f; in_rs1 = a; in_rs2 = b; in_tag = tg; in_bm = bm;
    n = 0;
    @(negedge clock);
    if (must_ready) chk("in_ready_b2b", 64'(in_ready), 64'(1));
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: tag %0h in_ready got 0 expected 1", tg);
    end else if (live) begin
      e.res = er; e.tag = tg; e.bm = ebm;
      e.cyc = lat ? cyc + STG : -1;
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending got %0d expected 0", sb.size());
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n;
    reset = 1'b0; in_valid = 1'b0; in_func = '0; in_rs1 = '0; in_rs2 = '0;
    in_tag = '0; in_bm = '0; br_resolve = '0; br_mispred = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_occupancy", 64'(occupancy), 64'(0));
    chk("rst_out_result", 64'(out_result), 64'(0));
    chk("rst_out_tag", 64'(out_tag), 64'(0));
    chk("rst_out_bm", 64'(out_bm), 64'(0));
    @(posedge clock);
    #1;
    reset = 1'b1;

    // single ops
    issue(2'b00, 32'd7, 32'hFFFF_FFFD, 6'd1, 4'b0, 32'hFFFF_FFEB, 4'b0, 1, 1, 0);
    wait_drain();
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd2, 4'b0, 32'hFFFF_FFFE, 4'b0, 1, 1, 0);
    wait_drain();

    // back-to-back
    issue(2'b01, 32'h8000_0000, 32'h8000_0000, 6'd3, 4'b0, 32'h4000_0000, 4'b0, 1, 1, 1);
    issue(2'b10, 32'hFFFF_FFFF, 32'd2, 6'd4, 4'b0, 32'hFFFF_FFFF, 4'b0, 1, 1, 1);
    wait_drain();

    // backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      issue(T3F[i], T3A[i], T3B[i], 6'(10 + i), 4'b0, T3R[i], 4'b0, 1, 0, 0);
    in_valid = 1'b1; in_func = 2'b00; in_rs1 = 32'd1; in_rs2 = 32'd1; in_tag = 6'd14; in_bm = '0;
    @(negedge clock);
    chk("in_ready_full", 64'(in_ready), 64'(0));
    chk("occ_full", 64'(occupancy), 64'(4));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    // mispredict squash of two of three in-flight ops
    issue(2'b00, 32'd6, 32'd7, 6'd20, 4'b0001, 32'd0, 4'b0, 0, 0, 0);
    issue(2'b00, 32'd6, 32'd7, 6'd21, 4'b0010, 32'd42, 4'b0010, 1, 1, 0);
    issue(2'b00, 32'd1, 32'd1, 6'd22, 4'b0001, 32'd0, 4'b0, 0, 0, 0);
    br_resolve = 4'b0001; br_mispred = 1'b1;
    @(negedge clock);
    chk("occ_pre_squash", 64'(occupancy), 64'(3));
    @(posedge clock);
    #1;
    br_resolve = '0; br_mispred = 1'b0;
    chk("occ_post_squash", 64'(occupancy), 64'(1));
    wait_drain();

    // kill of the op sitting in the output register
    out_ready = 1'b0;
    issue(2'b00, 32'd2, 32'd2, 6'd23, 4'b0100, 32'd0, 4'b0, 0, 0, 0);
    n = 0;
    @(negedge clock);
    while (!out_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("kill_reach_out", 64'(out_valid), 64'(1));
    @(posedge clock);
    #1;
    br_resolve = 4'b0100; br_mispred = 1'b1;
    #1;
    chk("kill_mask_valid", 64'(out_valid), 64'(0));
    chk("kill_mask_result", 64'(out_result), 64'(0));
    @(posedge clock);
    #1;
    br_resolve = '0; br_mispred = 1'b0;
    chk("kill_occ", 64'(occupancy), 64'(0));
    out_ready = 1'b1;

    // correct-predict clear mid-pipe, then at the output in the grant cycle
    issue(2'b00, 32'd9, 32'd9, 6'd30, 4'b0011, 32'd81, 4'b0010, 1, 1, 0);
    br_resolve = 4'b0001; br_mispred = 1'b0;
    @(posedge clock);
    #1;
    br_resolve = '0;
    wait_drain();
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd31, 4'b0100, 32'd1, 4'b0000, 1, 1, 0);
    repeat (3) @(posedge clock);
    #1;
    br_resolve = 4'b0100; br_mispred = 1'b0;
    @(posedge clock);
    #1;
    br_resolve = '0;
    wait_drain();

    // asynchronous reset with ops in flight
    issue(2'b00, 32'd1, 32'd2, 6'd40, 4'b0, 32'd0, 4'b0, 0, 0, 0);
    issue(2'b00, 32'd3, 32'd4, 6'd41, 4'b0, 32'd0, 4'b0, 0, 0, 0);
    issue(2'b00, 32'd5, 32'd6, 6'd42, 4'b0, 32'd0, 4'b0, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_occupancy", 64'(occupancy), 64'(0));
    chk("arst_in_ready", 64'(in_ready), 64'(1));
    chk("arst_out_tag", 64'(out_tag), 64'(0));
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    issue(2'b00, 32'd5, 32'd6, 6'd43, 4'b0, 32'd30, 4'b0, 1, 1, 0);
    wait_drain();
    repeat (4) @(posedge clock);
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mult_pipe.md
Name: mult_pipe

Overview:
- Parametrised pipelined integer multiplier for the RV32M/RV64M execute stage.
- Generalises the fixed-width multiply FU:
  - configurable operand width, stage count, branch-mask width and tag width;
  - true per-stage accumulation of partial products;
  - bubble-collapsing backpressure;
  - same-cycle branch squash/clear at every stage, including the output register.
- Sits between issue (input handshake) and the CDB arbiter (output handshake).

Parameters:
- XLEN, 32, operand/result width; legal values are 32 and 64.
- STAGES, 4, pipeline depth; must divide 2*XLEN; legal range 1..16.
- BM_W, 4, branch-mask width (one bit per in-flight branch).
- TAG_W, 6, destination physical-register tag width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  issue presents an op.
- in_ready  out  1  FU can accept this cycle.
- in_func  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- in_rs1  in  XLEN  multiplicand.
- in_rs2  in  XLEN  multiplier.
- in_tag  in  TAG_W  destination tag.
- in_bm  in  BM_W  branch dependency mask.
- br_resolve  in  BM_W  one-hot resolving branch; 0 means none.
- br_mispred  in  1  resolving branch was mispredicted.
- out_valid  out  1  result available to CDB.
- out_ready  in  1  CDB grant.
- out_result  out  XLEN  product slice.
- out_tag  out  TAG_W  destination tag.
- out_bm  out  BM_W  current mask of output op.
- occupancy  out  $clog2(STAGES+1)  number of valid stages.

Behaviour:
- Datapath:
  - SHIFT = 2*XLEN/STAGES.
  - Input stage sign- or zero-extends the operands to 2*XLEN:
    - rs1 is signed for MUL, MULH and MULHSU;
    - rs2 is signed for MUL and MULH.
  - Each stage k holds {valid, func, tag, bm, mcand, mplier, acc}.
  - On advance, the stage computes:
    - acc' = acc + mplier[SHIFT-1:0]*mcand (mod 2^(2XLEN));
    - mplier' = mplier >> SHIFT;
    - mcand' = mcand << SHIFT.
  - Stage 0 loads acc=0 plus the first partial product.
  - The final stage holds the complete product P.
  - out_result = P[XLEN-1:0] for MUL, else P[2XLEN-1:XLEN].
- Latency: with no stalls, an op accepted at edge t drives out_valid from t+STAGES-1 through to the edge at t+STAGES. Throughput is 1 op/cycle.
- Advance rule (bubble collapse):
  - The last stage advances/empties iff out_ready or it is invalid.
  - Stage k advances iff stage k+1 advances or stage k+1 is invalid.
  - in_ready = advance condition of stage 0. It is combinational from out_ready and valid bits only; there is no path from in_valid.
  - A non-advancing stage holds every field unchanged.
- Branch handling applies to every stage register, the output and the incoming op, with hit = |(bm & br_resolve):
  - hit & br_mispred: the op is killed and valid is cleared at the next edge. out_valid is masked combinationally that same cycle. An input op that is hit is not loaded, but in_ready is still reported.
  - hit & !br_mispred: the bm bit is cleared in the registered copy. out_bm shows the cleared value combinationally.
  - A killed final stage never asserts out_valid, so the CDB must not grant it. If out_ready arrives anyway it is ignored.
- Simultaneous events:
  - A stage killed this cycle counts as invalid for the advance rule of the stage behind it in the same cycle.
  - out_ready with a non-mispredicting resolve: the op leaves, and out_bm is already cleared.
- occupancy is the registered count of valid stages after squash.
- Reset (async, reset==0): all valid bits clear immediately.
  - Resulting outputs: in_ready=1, out_valid=0, occupancy=0.
  - out_result, out_tag and out_bm are 0.
  - Reset mid-operation discards all in-flight ops.
  - Deassertion is synchronised externally; the first accept is on the first edge with reset==1.
- X-safety: data fields of invalid stages are don't-care, but out_* are forced to 0 when out_valid=0.

Test Plan:
1. XLEN=32, STAGES=4, out_ready=1: MUL 7 * -3 -> out_result 0xFFFFFFEB exactly 4 cycles later. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
2. Back-to-back ops:
   - Stimulus: MULH 0x80000000*0x80000000, then MULHSU 0xFFFFFFFF*2 on consecutive cycles.
   - Required: results 0x40000000 then 0xFFFFFFFF on consecutive cycles; in_ready stays 1 throughout.
3. Backpressure:
   - Stimulus: hold out_ready=0 and issue 5 ops.
   - Required: 4 accepted; in_ready=0 on the 5th; occupancy=4.
   - Then release out_ready: results drain in order, tags preserved.
4. Mispredict squash:
   - Stimulus: three ops with bm 0001, 0010, 0001 in flight; br_resolve=0001, br_mispred=1.
   - Required: only the 0010 op emerges; occupancy drops from 3 to 1 on the next edge.
   - Also: a final-stage hit masks out_valid in the same cycle.
5. Correct-predict clear:
   - Stimulus: op with bm 0011; br_resolve=0001, br_mispred=0.
   - Required: out_bm=0010 at output; the result is unaffected.
6. Reset mid-flight:
   - Stimulus: assert reset=0 asynchronously, between edges, with 3 valid ops.
   - Required: out_valid=0 and occupancy=0 immediately; after release, a new MUL 5*6 -> 30.
